pcie_rst_seq: RTL and testbench

CSR-mapped PCIe reset sequencer for the sl28 CPLD. It takes the module reset and a slow clock enable, and releases the three PCIe reset outputs (A, B, C) one after another with a programmable inter-step delay. It sits on the shared CSR bus behind the I2C slave. Its active-high `pcie_rst[2:0]` outputs are inverted at top level to drive `PCIE_A/B/C_RST_n`, replacing the static misc-control bits.

---
 rtl/pcie_rst_seq_pkg.sv | 8 +
 rtl/pcie_rst_seq.sv | 128 ++++++++++++
 tb/tb_pcie_rst_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pcie_rst_seq_pkg.sv
// Shared CSR bus widths for sl28 CPLD register blocks.
package pcie_rst_seq_pkg;

   localparam int CSR_AW = 5;
   localparam int CSR_DW = 8;
   localparam int NUM_PORTS = 3;

endpackage

// File: rtl/pcie_rst_seq.sv
// PCIe reset sequencer: releases ports A, B, C in order with a
// CSR-programmable inter-step delay counted in ce ticks.
module pcie_rst_seq
   import pcie_rst_seq_pkg::*;
#(
   parameter logic [4:0] BASE_ADDR     = 5'h0,
   parameter logic [7:0] DEFAULT_DELAY = 8'd1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic [4:0] csr_a,
   input  logic [7:0] csr_di,
   input  logic       csr_we,
   output logic [7:0] csr_do,
   output logic [2:0] pcie_rst,
   output logic       busy
);

   localparam logic [CSR_AW-1:0] REG_CTRL  = 5'd0;
   localparam logic [CSR_AW-1:0] REG_DELAY = 5'd1;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_C    = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [CSR_DW-1:0]    cnt_q;
   logic [CSR_DW-1:0]    cnt_d;
   logic [CSR_DW-1:0]    delay_q;
   logic [CSR_DW-1:0]    delay_d;
   logic [NUM_PORTS-1:0] hold_q;
   logic [NUM_PORTS-1:0] hold_d;
   logic [NUM_PORTS-1:0] force_q;
   logic [NUM_PORTS-1:0] force_d;
   logic                 busy_d;

   logic sel_ctrl;
   logic sel_delay;
   logic wr_ctrl;
   logic wr_delay;
   logic restart;

   assign sel_ctrl  = (csr_a == (BASE_ADDR + REG_CTRL));
   assign sel_delay = (csr_a == (BASE_ADDR + REG_DELAY));
   assign wr_ctrl   = csr_we & sel_ctrl;
   assign wr_delay  = csr_we & sel_delay;
   assign restart   = wr_ctrl & csr_di[7];

   // CSR register file; force has no influence on the sequencer
   always_comb begin
      force_d = force_q;
      delay_d = delay_q;
      if (wr_ctrl)
         force_d = csr_di[2:0];
      if (wr_delay)
         delay_d = csr_di;
   end

   always_comb begin
      csr_do = 8'h00;
      if (sel_ctrl)
         csr_do = {1'b0, busy, 3'b000, force_q};
      else if (sel_delay)
         csr_do = delay_q;
   end

   // Restart outranks a coincident ce tick; reloads use the
   // pre-write DELAY value.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      if (restart) begin
         state_d = S_A;
         cnt_d   = delay_q;
         hold_d  = 3'b111;
      end else if (ce && state_q != S_DONE) begin
         if (cnt_q == 8'd0) begin
            cnt_d = delay_q;
            unique case (state_q)
               S_A: begin
                  hold_d[0] = 1'b0;
                  state_d   = S_B;
               end
               S_B: begin
                  hold_d[1] = 1'b0;
                  state_d   = S_C;
               end
               S_C: begin
                  hold_d[2] = 1'b0;
                  state_d   = S_DONE;
               end
               default: ;
            endcase
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
      busy_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_A;
         cnt_q    <= DEFAULT_DELAY;
         delay_q  <= DEFAULT_DELAY;
         hold_q   <= 3'b111;
         force_q  <= 3'b000;
         pcie_rst <= 3'b111;
         busy     <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         delay_q  <= delay_d;
         hold_q   <= hold_d;
         force_q  <= force_d;
         pcie_rst <= hold_d | force_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_pcie_rst_seq.sv
// Scoreboard bench for pcie_rst_seq: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_pcie_rst_seq;

   localparam logic [4:0] BASE = 5'h08;
   localparam logic [4:0] A_CTRL = BASE;
   localparam logic [4:0] A_DLY = BASE + 5'd1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b0;
   logic [4:0] csr_a = 5'h00;
   logic [7:0] csr_di = 8'h00;
   logic       csr_we = 1'b0;
   logic [7:0] csr_do;
   logic [2:0] pcie_rst;
   logic       busy;

   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      logic       is_rd;
      logic [2:0] rst_v;
      logic       busy_v;
      logic [7:0] rd_v;
   } item_t;

   item_t sb[$];

   pcie_rst_seq #(
      .BASE_ADDR(BASE),
      .DEFAULT_DELAY(8'd1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ce(ce),
      .csr_a(csr_a),
      .csr_di(csr_di),
      .csr_we(csr_we),
      .csr_do(csr_do),
      .pcie_rst(pcie_rst),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         item_t it;
         it = sb.pop_front();
         n_tests++;
         if (it.is_rd) begin
            if (csr_do !== it.rd_v) begin
               n_fail++;
               $display("FAIL %s: csr_do=%h expected %h",
                        it.name, csr_do, it.rd_v);
            end
         end else if (pcie_rst !== it.rst_v || busy !== it.busy_v) begin
            n_fail++;
            $display("FAIL %s: pcie_rst=%b busy=%b expected %b/%b",
                     it.name, pcie_rst, busy, it.rst_v, it.busy_v);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      ce = 1'b1;
      step();
      ce = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d,
                     input logic with_ce);
      csr_a  = a;
      csr_di = d;
      csr_we = 1'b1;
      ce     = with_ce;
      step();
      csr_we = 1'b0;
      ce     = 1'b0;
   endtask

   task automatic exp_o(input string n, input logic [2:0] r,
                        input logic b);
      item_t it;
      it.name = n;
      it.is_rd = 1'b0;
      it.rst_v = r;
      it.busy_v = b;
      it.rd_v = 8'h00;
      sb.push_back(it);
      @(negedge clk);
      #1;
   endtask

   task automatic exp_rd(input string n, input logic [4:0] a,
                         input logic [7:0] d);
      item_t it;
      csr_a = a;
      it.name = n;
      it.is_rd = 1'b1;
      it.rst_v = 3'b000;
      it.busy_v = 1'b0;
      it.rd_v = d;
      sb.push_back(it);
      @(negedge clk);
      #1;
   endtask

   task automatic tick_exp(input string n, input logic [2:0] r,
                           input logic b);
      tick();
      exp_o(n, r, b);
   endtask

   initial begin
      // reset defaults
      repeat (3) step();
      exp_o("rst_out", 3'b111, 1'b1);
      exp_rd("rst_ctrl", A_CTRL, 8'h40);
      exp_rd("rst_dly", A_DLY, 8'h01);
      rst = 1'b0;
      step();
      tick_exp("def_t1", 3'b111, 1'b1);
      tick_exp("def_t2", 3'b110, 1'b1);
      tick_exp("def_t3", 3'b110, 1'b1);
      tick_exp("def_t4", 3'b100, 1'b1);
      tick_exp("def_t5", 3'b100, 1'b1);
      tick_exp("def_t6", 3'b000, 1'b0);
      exp_rd("def_ctrl", A_CTRL, 8'h00);
      tick_exp("done_ce_ign", 3'b000, 1'b0);

      // DELAY = 0 and decode
      wr(A_DLY, 8'h00, 1'b0);
      exp_rd("d0_rd", A_DLY, 8'h00);
      wr(A_CTRL, 8'h80, 1'b0);
      exp_o("d0_restart", 3'b111, 1'b1);
      exp_rd("d0_ctrl_busy", A_CTRL, 8'h40);
      tick_exp("d0_t1", 3'b110, 1'b1);
      tick_exp("d0_t2", 3'b100, 1'b1);
      tick_exp("d0_t3", 3'b000, 1'b0);
      exp_rd("unmap_0a", 5'h0A, 8'h00);
      exp_rd("unmap_00", 5'h00, 8'h00);
      exp_rd("unmap_1f", 5'h1F, 8'h00);

      // restart colliding with ce in S_B
      wr(A_DLY, 8'h01, 1'b0);
      wr(A_CTRL, 8'h80, 1'b0);
      tick_exp("col_t1", 3'b111, 1'b1);
      tick_exp("col_t2", 3'b110, 1'b1);
      wr(A_CTRL, 8'h80, 1'b1);
      exp_o("col_restart", 3'b111, 1'b1);
      tick_exp("col_r1", 3'b111, 1'b1);
      tick_exp("col_r2", 3'b110, 1'b1);
      tick_exp("col_r3", 3'b110, 1'b1);
      tick_exp("col_r4", 3'b100, 1'b1);
      tick_exp("col_r5", 3'b100, 1'b1);
      tick_exp("col_r6", 3'b000, 1'b0);

      // force in S_DONE
      wr(A_CTRL, 8'h05, 1'b0);
      exp_o("frc_on", 3'b101, 1'b0);
      exp_rd("frc_rd", A_CTRL, 8'h05);
      tick_exp("frc_ce", 3'b101, 1'b0);
      wr(A_CTRL, 8'h00, 1'b0);
      exp_o("frc_off", 3'b000, 1'b0);

      // DELAY write mid-step
      wr(A_DLY, 8'h03, 1'b0);
      wr(A_CTRL, 8'h80, 1'b0);
      tick_exp("mid_t1", 3'b111, 1'b1);
      wr(A_DLY, 8'h00, 1'b0);
      tick_exp("mid_t2", 3'b111, 1'b1);
      tick_exp("mid_t3", 3'b111, 1'b1);
      tick_exp("mid_t4", 3'b110, 1'b1);
      tick_exp("mid_t5", 3'b100, 1'b1);
      tick_exp("mid_t6", 3'b000, 1'b0);

      // reset mid-sequence, in S_C
      wr(A_CTRL, 8'h80, 1'b0);
      tick_exp("rs_t1", 3'b110, 1'b1);
      tick_exp("rs_t2", 3'b100, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      exp_o("rs_async", 3'b111, 1'b1);
      exp_rd("rs_dly_def", A_DLY, 8'h01);
      rst = 1'b0;
      step();
      tick_exp("rs_r1", 3'b111, 1'b1);
      tick_exp("rs_r2", 3'b110, 1'b1);

      for (int i = 0; i < 10 && sb.size() > 0; i++)
         @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
